uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver_if.sv | 20 ++
 rtl/uart_receiver.sv | 129 ++++++++++++
 tb/tb_uart_receiver.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_if.sv
// Bundles the receiver's serial input and its parallel result and status outputs.
// The line/consumer side connects through master and the receiver through slave.
interface uart_receiver_if;
   logic       RX_datain;
   logic [7:0] RX_DATA;
   logic       RX_valid;
   logic       parity_error;
   logic       framing_error;
   logic       RX_busy;

   modport master (
      output RX_datain,
      input  RX_DATA, RX_valid, parity_error, framing_error, RX_busy
   );

   modport slave (
      input  RX_datain,
      output RX_DATA, RX_valid, parity_error, framing_error, RX_busy
   );
endinterface

// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits, even parity, 1 stop bit, bits sampled at mid-bit.
// Result and error flags are registered one cycle after the stop-bit sample.
//
// state     | meaning
// IDLE      | line idle, waiting for rxs low
// START     | timing half a bit to confirm the start bit
// DATA      | sampling 8 data bits, LSB first
// PARITY    | sampling the parity bit
// STOP      | sampling the stop bit
// WAIT_IDLE | stop bit was low (break), waiting for the line to go high
module uart_receiver #(
   parameter int CLKS_PER_BIT = 16
) (
   input logic            clk,
   input logic            reset,
   uart_receiver_if.slave bus
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

   state_t        state, state_nxt;
   logic          rx_meta, rxs;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          parity_bit;
   logic          stop_bit;
   logic          done;
   logic          sample_pt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= bus.RX_datain;
         rxs     <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      sample_pt = 1'b0;
      case (state)
         IDLE: begin
            if (!rxs) state_nxt = START;
         end
         START: begin
            sample_pt = (cnt == HALF);
            if (sample_pt) state_nxt = rxs ? IDLE : DATA;
         end
         DATA: begin
            sample_pt = (cnt == FULL);
            if (sample_pt && bit_idx == 3'd7) state_nxt = PARITY;
         end
         PARITY: begin
            sample_pt = (cnt == FULL);
            if (sample_pt) state_nxt = STOP;
         end
         STOP: begin
            sample_pt = (cnt == FULL);
            if (sample_pt) state_nxt = rxs ? IDLE : WAIT_IDLE;
         end
         WAIT_IDLE: begin
            if (rxs) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Counter sits at 0 while idle so the START half-bit is timed from T0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (state == IDLE || state == WAIT_IDLE || sample_pt) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_idx    <= 3'd0;
         shift      <= 8'h00;
         parity_bit <= 1'b0;
         stop_bit   <= 1'b1;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == START) bit_idx <= 3'd0;
         if (state == DATA && sample_pt) begin
            shift[bit_idx] <= rxs;
            bit_idx        <= bit_idx + 3'd1;
         end
         if (state == PARITY && sample_pt) parity_bit <= rxs;
         if (state == STOP && sample_pt) begin
            stop_bit <= rxs;
            done     <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.RX_DATA       <= 8'h00;
         bus.RX_valid      <= 1'b0;
         bus.parity_error  <= 1'b0;
         bus.framing_error <= 1'b0;
      end else begin
         bus.RX_valid <= done;
         if (done) begin
            bus.RX_DATA       <= shift;
            bus.parity_error  <= parity_bit ^ (^shift);
            bus.framing_error <= ~stop_bit;
         end
      end
   end

   assign bus.RX_busy = (state != IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit; pulses are timestamped
// by a monitor and checked against hand-computed bytes, flags and cycle counts.
module tb_uart_receiver;
   localparam int CPB = 16;

   logic clk;
   logic reset;
   int   cyc;
   int   vcount;
   int   last_cyc;
   int   prev_cyc;
   int   vectors;
   int   miscompares;
   int   fc, fc1, base;

   uart_receiver_if bus ();

   uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      vcount   = 0;
      last_cyc = 0;
      prev_cyc = 0;
   end
   always @(negedge clk) begin
      if (bus.RX_valid) begin
         vcount   <= vcount + 1;
         prev_cyc <= last_cyc;
         last_cyc <= cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Caller must be at a negedge; returns at the negedge ending the stop bit.
   task automatic send_frame(input logic [7:0] d, input logic p, input logic s, output int fall);
      logic [10:0] bits;
      bits = {s, p, d, 1'b0};
      fall = cyc;
      for (int k = 0; k < 11; k++) begin
         bus.RX_datain = bits[k];
         repeat (CPB) @(negedge clk);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset         = 1'b0;
      bus.RX_datain = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_data",  {24'd0, bus.RX_DATA}, 32'h00);
      check("rst_valid", {31'd0, bus.RX_valid}, 32'd0);
      check("rst_perr",  {31'd0, bus.parity_error}, 32'd0);
      check("rst_ferr",  {31'd0, bus.framing_error}, 32'd0);
      check("rst_busy",  {31'd0, bus.RX_busy}, 32'd0);
      reset = 1'b1;
      repeat (5) @(negedge clk);

      // Good frame 0xA5: pulse 172 cycles after the line falls (T0 = fall+3).
      send_frame(8'hA5, 1'b0, 1'b1, fc);
      bus.RX_datain = 1'b1;
      repeat (20) @(negedge clk);
      check("a5_count", vcount, 32'd1);
      check("a5_time",  last_cyc - fc, 32'd172);
      check("a5_data",  {24'd0, bus.RX_DATA}, 32'hA5);
      check("a5_perr",  {31'd0, bus.parity_error}, 32'd0);
      check("a5_ferr",  {31'd0, bus.framing_error}, 32'd0);
      check("a5_busy",  {31'd0, bus.RX_busy}, 32'd0);

      // 0x01 needs parity 1; sending 0 flags a parity error.
      send_frame(8'h01, 1'b0, 1'b1, fc);
      repeat (20) @(negedge clk);
      check("p01_count", vcount, 32'd2);
      check("p01_data",  {24'd0, bus.RX_DATA}, 32'h01);
      check("p01_perr",  {31'd0, bus.parity_error}, 32'd1);
      check("p01_ferr",  {31'd0, bus.framing_error}, 32'd0);

      // 0x3C with a low stop bit, line held low 40 more bit times.
      send_frame(8'h3C, 1'b0, 1'b0, fc);
      repeat (40 * CPB) @(negedge clk);
      check("brk_count", vcount, 32'd3);
      check("brk_data",  {24'd0, bus.RX_DATA}, 32'h3C);
      check("brk_ferr",  {31'd0, bus.framing_error}, 32'd1);
      check("brk_perr",  {31'd0, bus.parity_error}, 32'd0);
      check("brk_busy",  {31'd0, bus.RX_busy}, 32'd1);
      bus.RX_datain = 1'b1;
      repeat (5) @(negedge clk);
      check("brk_idle",  {31'd0, bus.RX_busy}, 32'd0);
      repeat (20) @(negedge clk);
      check("brk_count2", vcount, 32'd3);

      // 4-cycle glitch: START confirms high at T0+8 and drops back to IDLE.
      fc = cyc;
      bus.RX_datain = 1'b0;
      repeat (4) @(negedge clk);
      bus.RX_datain = 1'b1;
      repeat (2) @(negedge clk);
      check("gl_busy_hi", {31'd0, bus.RX_busy}, 32'd1);
      repeat (6) @(negedge clk);
      check("gl_busy_lo", {31'd0, bus.RX_busy}, 32'd0);
      check("gl_at", cyc - fc, 32'd12);
      repeat (200) @(negedge clk);
      check("gl_count", vcount, 32'd3);
      check("gl_data",  {24'd0, bus.RX_DATA}, 32'h3C);
      check("gl_ferr",  {31'd0, bus.framing_error}, 32'd1);

      // Back-to-back 0x55 then 0xFF with no idle gap.
      send_frame(8'h55, 1'b0, 1'b1, fc1);
      check("b2b_first", {24'd0, bus.RX_DATA}, 32'h55);
      check("b2b_ferr1", {31'd0, bus.framing_error}, 32'd0);
      send_frame(8'hFF, 1'b0, 1'b1, fc);
      bus.RX_datain = 1'b1;
      repeat (20) @(negedge clk);
      check("b2b_count", vcount, 32'd5);
      check("b2b_gap",   last_cyc - prev_cyc, 32'd176);
      check("b2b_data",  {24'd0, bus.RX_DATA}, 32'hFF);
      check("b2b_perr",  {31'd0, bus.parity_error}, 32'd0);
      check("b2b_ferr",  {31'd0, bus.framing_error}, 32'd0);

      // Partial frame 0x7E, reset in the middle of data bit 4.
      base = vcount;
      bus.RX_datain = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         bus.RX_datain = (k == 0) ? 1'b0 : 1'b1;
         repeat (CPB) @(negedge clk);
      end
      bus.RX_datain = 1'b1;
      repeat (CPB / 2) @(negedge clk);
      check("mid_hold", {24'd0, bus.RX_DATA}, 32'hFF);
      check("mid_busy", {31'd0, bus.RX_busy}, 32'd1);
      reset = 1'b0;
      #1;
      check("mr_data",  {24'd0, bus.RX_DATA}, 32'h00);
      check("mr_valid", {31'd0, bus.RX_valid}, 32'd0);
      check("mr_perr",  {31'd0, bus.parity_error}, 32'd0);
      check("mr_ferr",  {31'd0, bus.framing_error}, 32'd0);
      check("mr_busy",  {31'd0, bus.RX_busy}, 32'd0);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      repeat (CPB * 12) @(negedge clk);
      check("mr_count0", vcount - base, 32'd0);
      send_frame(8'h81, 1'b0, 1'b1, fc);
      repeat (20) @(negedge clk);
      check("mr_count", vcount - base, 32'd1);
      check("mr_time",  last_cyc - fc, 32'd172);
      check("mr_rdata", {24'd0, bus.RX_DATA}, 32'h81);
      check("mr_rperr", {31'd0, bus.parity_error}, 32'd0);
      check("mr_rferr", {31'd0, bus.framing_error}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
